// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash sample playback path.
package flash_audio_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam int SAMPLE_W     = 16;
  localparam int FLASH_WORD_W = 2 * SAMPLE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_OUT_LO,
    ST_OUT_HI,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/flash_sample_sequencer_if.sv
// Flash read handshake bundle between the sample sequencer (master) and the flash reader (slave).
interface flash_sample_sequencer_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              get_address;
  logic              address_ready;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    input  get_address,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid,
    output address_ready,
    output flash_mem_address
  );

  modport slave (
    output get_address,
    output flash_mem_readdata,
    output flash_mem_readdatavalid,
    input  address_ready,
    input  flash_mem_address
  );
endinterface

// File: rtl/sample_splitter.sv
// Holds one fetched flash word and releases its low then high half as audio samples.
module sample_splitter #(
  parameter int SAMPLE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic [2*SAMPLE_W-1:0] i_word,
  input  logic                  i_emit_lo,
  input  logic                  i_emit_hi,
  output logic [SAMPLE_W-1:0]   o_sample,
  output logic                  o_valid
);

  logic [2*SAMPLE_W-1:0] r_word;
  logic [SAMPLE_W-1:0]   r_sample;
  logic                  r_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= i_emit_lo | i_emit_hi;
      if (i_load) r_word <= i_word;
      if (i_emit_lo)      r_sample <= r_word[SAMPLE_W-1:0];
      else if (i_emit_hi) r_sample <= r_word[2*SAMPLE_W-1:SAMPLE_W];
    end
  end

  assign o_sample = r_sample;
  assign o_valid  = r_valid;

endmodule

// File: rtl/flash_sample_sequencer.sv
// Walks a flash word range, fetches each word and plays it out as two PCM samples on sample ticks.
// Optional FLASH_SEQ_LOOP_EN adds a loop input that restarts the range instead of finishing.
module flash_sample_sequencer #(
  parameter int ADDR_W   = 23,
  parameter int SAMPLE_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W-1:0]       end_addr,
  input  logic                    abort,
  input  logic                    sample_tick,
`ifdef FLASH_SEQ_LOOP_EN
  input  logic                    loop,
`endif
  flash_sample_sequencer_if.master flash_bus,
  output logic [SAMPLE_W-1:0]     audio_sample,
  output logic                    audio_valid,
  output logic                    busy,
  output logic                    done
);
  import flash_audio_pkg::*;

  seq_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_end, w_end_nxt;
`ifdef FLASH_SEQ_LOOP_EN
  logic [ADDR_W-1:0] r_first, w_first_nxt;
`endif
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_areq, w_areq_nxt;
  logic              w_load, w_emit_lo, w_emit_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_end   <= '0;
`ifdef FLASH_SEQ_LOOP_EN
      r_first <= '0;
`endif
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_areq  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_end   <= w_end_nxt;
`ifdef FLASH_SEQ_LOOP_EN
      r_first <= w_first_nxt;
`endif
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_areq  <= w_areq_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_end_nxt   = r_end;
`ifdef FLASH_SEQ_LOOP_EN
    w_first_nxt = r_first;
`endif
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_areq_nxt  = 1'b0;
    w_load      = 1'b0;
    w_emit_lo   = 1'b0;
    w_emit_hi   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_addr_nxt  = start_addr;
          w_end_nxt   = end_addr;
`ifdef FLASH_SEQ_LOOP_EN
          w_first_nxt = start_addr;
`endif
          w_busy_nxt  = 1'b1;
          w_state_nxt = (start_addr > end_addr) ? ST_FINISH : ST_REQ;
        end
      end
      // Waiting on get_address lets a reader transaction orphaned by reset drain first.
      ST_REQ: begin
        if (flash_bus.get_address) begin
          w_areq_nxt  = 1'b1;
          w_state_nxt = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (flash_bus.flash_mem_readdatavalid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_OUT_LO;
        end
      end
      ST_OUT_LO: begin
        if (sample_tick) begin
          w_emit_lo   = 1'b1;
          w_state_nxt = ST_OUT_HI;
        end
      end
      // Terminate on equality so a range ending at the top address never wraps.
      ST_OUT_HI: begin
        if (sample_tick) begin
          w_emit_hi = 1'b1;
          if (r_addr == r_end) begin
`ifdef FLASH_SEQ_LOOP_EN
            if (loop) begin
              w_addr_nxt  = r_first;
              w_state_nxt = ST_REQ;
            end else
`endif
            w_state_nxt = ST_FINISH;
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_FINISH: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (abort && (r_state != ST_IDLE) && (r_state != ST_FINISH)) begin
      w_state_nxt = ST_FINISH;
      w_addr_nxt  = r_addr;
      w_areq_nxt  = 1'b0;
      w_load      = 1'b0;
      w_emit_lo   = 1'b0;
      w_emit_hi   = 1'b0;
    end
  end

  sample_splitter #(.SAMPLE_W(SAMPLE_W)) u_splitter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_word   (flash_bus.flash_mem_readdata),
    .i_emit_lo(w_emit_lo),
    .i_emit_hi(w_emit_hi),
    .o_sample (audio_sample),
    .o_valid  (audio_valid)
  );

  assign flash_bus.address_ready     = r_areq;
  assign flash_bus.flash_mem_address = r_addr;
  assign busy                        = r_busy;
  assign done                        = r_done;

endmodule
